// File: rtl/iod_rx_lane_pause_pkg.sv
// Shared types and default timing for the RX lane pause controller.
package iod_rx_lane_pause_pkg;

  localparam int EYE_W                  = 3;
  localparam int DEF_PAUSE_SETUP_CYCLES = 4;
  localparam int DEF_PAUSE_HOLD_CYCLES  = 4;
  localparam int DEF_SETTLE_CYCLES      = 16;
  localparam int DEF_CNT_W              = 8;

  typedef enum logic [2:0] {
    ST_INIT        = 3'd0,
    ST_IDLE        = 3'd1,
    ST_PAUSE_SETUP = 3'd2,
    ST_APPLY       = 3'd3,
    ST_PAUSE_HOLD  = 3'd4,
    ST_SETTLE      = 3'd5,
    ST_CHECK       = 3'd6
  } state_t;

endpackage

// File: rtl/iod_lane_pause_timer.sv
// Loadable down-counter shared by the timed states. It holds at zero and never wraps.
module iod_lane_pause_timer #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic [CNT_W-1:0] o_value,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // Load on state entry, otherwise count down and stop at zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_value = r_cnt;
  assign o_zero  = (r_cnt == '0);

endmodule

// File: rtl/iod_rx_lane_pause_ctrl.sv
// Sequences eye-monitor width changes and bit-slips inside a guarded
// HS_IO_CLK_PAUSE window, reads the width back and handshakes completion.
// Handshake: REQ is a level held until the one-cycle ACK pulse; a request is
// accepted only in IDLE once REQ has been seen low since the previous accept.
module iod_rx_lane_pause_ctrl
  import iod_rx_lane_pause_pkg::*;
#(
  parameter int               PAUSE_SETUP_CYCLES = DEF_PAUSE_SETUP_CYCLES,
  parameter int               PAUSE_HOLD_CYCLES  = DEF_PAUSE_HOLD_CYCLES,
  parameter int               SETTLE_CYCLES      = DEF_SETTLE_CYCLES,
  parameter logic [EYE_W-1:0] INIT_WIDTH         = 3'b000,
  parameter int               CNT_W              = DEF_CNT_W
) (
  input  logic             FAB_CLK,
  input  logic             RESET,
  input  logic             REQ,
  input  logic [EYE_W-1:0] REQ_WIDTH,
  input  logic             REQ_SLIP,
  output logic             ACK,
  output logic             BUSY,
  output logic             LANE_READY,
  output logic             WIDTH_ERR,
  output logic             HS_IO_CLK_PAUSE,
  output logic [EYE_W-1:0] EYE_MONITOR_WIDTH_IN,
  output logic             RX_BIT_SLIP,
  input  logic [EYE_W-1:0] EYE_MONITOR_WIDTH_OUT,
  output logic [2:0]       o_dbg_state,
  output logic [CNT_W-1:0] o_dbg_timer
);

  localparam logic [CNT_W-1:0] LD_SETUP  = CNT_W'(PAUSE_SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_HOLD   = CNT_W'(PAUSE_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_SETTLE = CNT_W'(SETTLE_CYCLES - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic             w_accept;
  logic             w_tmr_load;
  logic [CNT_W-1:0] w_tmr_val;
  logic             w_tmr_zero;
  logic             w_pause_nxt;

  logic             r_rearm;
  logic [EYE_W-1:0] r_pend_width;
  logic             r_pend_slip;

  iod_lane_pause_timer #(.CNT_W(CNT_W)) u_timer (
    .i_clk      (FAB_CLK),
    .i_rst      (RESET),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_value    (o_dbg_timer),
    .o_zero     (w_tmr_zero)
  );

  // State register.
  always_ff @(posedge FAB_CLK or posedge RESET) begin
    if (RESET) r_state <= ST_INIT;
    else       r_state <= w_next_state;
  end

  // Next-state decode and request acceptance.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      ST_INIT:        w_next_state = ST_PAUSE_SETUP;
      ST_IDLE: begin
        if (REQ && LANE_READY && r_rearm) begin
          w_accept     = 1'b1;
          w_next_state = ST_PAUSE_SETUP;
        end
      end
      ST_PAUSE_SETUP: if (w_tmr_zero) w_next_state = ST_APPLY;
      ST_APPLY:       w_next_state = ST_PAUSE_HOLD;
      ST_PAUSE_HOLD:  if (w_tmr_zero) w_next_state = ST_SETTLE;
      ST_SETTLE:      if (w_tmr_zero) w_next_state = ST_CHECK;
      ST_CHECK:       w_next_state = ST_IDLE;
      default:        w_next_state = ST_INIT;
    endcase
  end

  // Timer is reloaded with N-1 on entry into each timed state.
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    if (w_next_state != r_state) begin
      case (w_next_state)
        ST_PAUSE_SETUP: begin w_tmr_load = 1'b1; w_tmr_val = LD_SETUP;  end
        ST_PAUSE_HOLD:  begin w_tmr_load = 1'b1; w_tmr_val = LD_HOLD;   end
        ST_SETTLE:      begin w_tmr_load = 1'b1; w_tmr_val = LD_SETTLE; end
        default:        begin w_tmr_load = 1'b0; w_tmr_val = '0;        end
      endcase
    end
  end

  // The pause window covers setup, the apply cycle and hold.
  always_comb begin
    w_pause_nxt = 1'b0;
    if (w_next_state == ST_PAUSE_SETUP || w_next_state == ST_APPLY ||
        w_next_state == ST_PAUSE_HOLD) begin
      w_pause_nxt = 1'b1;
    end
  end

  // Outputs are registered from the next state, so each is visible in the
  // same cycle as the state it belongs to.
  always_ff @(posedge FAB_CLK or posedge RESET) begin
    if (RESET) begin
      HS_IO_CLK_PAUSE      <= 1'b0;
      EYE_MONITOR_WIDTH_IN <= INIT_WIDTH;
      RX_BIT_SLIP          <= 1'b0;
      ACK                  <= 1'b0;
      BUSY                 <= 1'b0;
      LANE_READY           <= 1'b0;
      WIDTH_ERR            <= 1'b0;
      r_rearm              <= 1'b1;
      r_pend_width         <= INIT_WIDTH;
      r_pend_slip          <= 1'b0;
    end else begin
      HS_IO_CLK_PAUSE <= w_pause_nxt;
      RX_BIT_SLIP     <= (w_next_state == ST_APPLY) && r_pend_slip;
      BUSY            <= (w_next_state != ST_IDLE);
      // The init sequence runs while LANE_READY is still low and is not acked.
      ACK             <= (w_next_state == ST_CHECK) && LANE_READY;
      if (w_next_state == ST_APPLY) EYE_MONITOR_WIDTH_IN <= r_pend_width;
      if (w_next_state == ST_CHECK) begin
        LANE_READY <= 1'b1;
        if (EYE_MONITOR_WIDTH_OUT != EYE_MONITOR_WIDTH_IN) WIDTH_ERR <= 1'b1;
      end
      if (r_state == ST_INIT) begin
        r_pend_width <= INIT_WIDTH;
        r_pend_slip  <= 1'b0;
      end
      if (w_accept) begin
        r_pend_width <= REQ_WIDTH;
        r_pend_slip  <= REQ_SLIP;
        WIDTH_ERR    <= 1'b0;
        r_rearm      <= 1'b0;
      end else if (r_state == ST_IDLE && !REQ) begin
        r_rearm <= 1'b1;
      end
    end
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_iod_rx_lane_pause_ctrl.sv
// Directed bench for iod_rx_lane_pause_ctrl with default timing parameters.
module tb_iod_rx_lane_pause_ctrl;

  logic       FAB_CLK = 1'b0;
  logic       RESET   = 1'b1;
  logic       REQ     = 1'b0;
  logic [2:0] REQ_WIDTH = 3'b000;
  logic       REQ_SLIP  = 1'b0;
  logic       ACK, BUSY, LANE_READY, WIDTH_ERR, HS_IO_CLK_PAUSE, RX_BIT_SLIP;
  logic [2:0] EYE_MONITOR_WIDTH_IN, EYE_MONITOR_WIDTH_OUT;
  logic [2:0] dbg_state;
  logic [7:0] dbg_timer;

  logic       loop_en  = 1'b1;
  logic [2:0] forced_w = 3'b000;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [2:0] req_width;
    logic       req_slip;
    logic       loop;
    logic [2:0] forced;
    logic [2:0] exp_width;
    logic       exp_err;
  } vec_t;

  vec_t vecs[6];

  // Lane model: readback either follows the applied width or is stuck.
  assign EYE_MONITOR_WIDTH_OUT = loop_en ? EYE_MONITOR_WIDTH_IN : forced_w;

  iod_rx_lane_pause_ctrl dut (
    .FAB_CLK               (FAB_CLK),
    .RESET                 (RESET),
    .REQ                   (REQ),
    .REQ_WIDTH             (REQ_WIDTH),
    .REQ_SLIP              (REQ_SLIP),
    .ACK                   (ACK),
    .BUSY                  (BUSY),
    .LANE_READY            (LANE_READY),
    .WIDTH_ERR             (WIDTH_ERR),
    .HS_IO_CLK_PAUSE       (HS_IO_CLK_PAUSE),
    .EYE_MONITOR_WIDTH_IN  (EYE_MONITOR_WIDTH_IN),
    .RX_BIT_SLIP           (RX_BIT_SLIP),
    .EYE_MONITOR_WIDTH_OUT (EYE_MONITOR_WIDTH_OUT),
    .o_dbg_state           (dbg_state),
    .o_dbg_timer           (dbg_timer)
  );

  // Clock.
  always #5 FAB_CLK = ~FAB_CLK;

  task automatic tick();
    @(posedge FAB_CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Called in the accept (or reset-release) cycle T with REQ already set.
  // Walks T+1..T+27 checking every output against the fixed schedule.
  task automatic check_seq(input logic [2:0] old_w, input logic [2:0] new_w,
                           input logic slip, input logic is_init, input logic exp_err);
    for (int k = 1; k <= 27; k++) begin
      tick();
      chk($sformatf("pause k=%0d", k), {7'd0, HS_IO_CLK_PAUSE}, {7'd0, (k <= 9)});
      chk($sformatf("width k=%0d", k), {5'd0, EYE_MONITOR_WIDTH_IN},
          {5'd0, (k >= 5) ? new_w : old_w});
      chk($sformatf("slip k=%0d", k), {7'd0, RX_BIT_SLIP}, {7'd0, (k == 5) && slip});
      chk($sformatf("ack k=%0d", k), {7'd0, ACK}, {7'd0, (k == 26) && !is_init});
      chk($sformatf("busy k=%0d", k), {7'd0, BUSY}, {7'd0, (k <= 26)});
      chk($sformatf("ready k=%0d", k), {7'd0, LANE_READY},
          {7'd0, is_init ? (k >= 26) : 1'b1});
      chk($sformatf("werr k=%0d", k), {7'd0, WIDTH_ERR},
          {7'd0, (k >= 26) ? exp_err : 1'b0});
      if (k == 26) REQ = 1'b0;
    end
  endtask

  // One idle cycle with REQ low to rearm, then raise the request.
  task automatic do_req(input logic [2:0] w, input logic slip);
    tick();
    REQ       = 1'b1;
    REQ_WIDTH = w;
    REQ_SLIP  = slip;
  endtask

  initial begin
    logic [2:0] cur_w;
    int         acks;

    vecs[0] = '{req_width: 3'b101, req_slip: 1'b0, loop: 1'b1, forced: 3'b000, exp_width: 3'b101, exp_err: 1'b0};
    vecs[1] = '{req_width: 3'b101, req_slip: 1'b1, loop: 1'b1, forced: 3'b000, exp_width: 3'b101, exp_err: 1'b0};
    vecs[2] = '{req_width: 3'b011, req_slip: 1'b0, loop: 1'b0, forced: 3'b000, exp_width: 3'b011, exp_err: 1'b1};
    vecs[3] = '{req_width: 3'b110, req_slip: 1'b0, loop: 1'b1, forced: 3'b000, exp_width: 3'b110, exp_err: 1'b0};
    vecs[4] = '{req_width: 3'b110, req_slip: 1'b0, loop: 1'b1, forced: 3'b000, exp_width: 3'b110, exp_err: 1'b0};
    vecs[5] = '{req_width: 3'b000, req_slip: 1'b1, loop: 1'b1, forced: 3'b000, exp_width: 3'b000, exp_err: 1'b0};

    // Reset values while RESET is held.
    repeat (3) tick();
    chk("rst pause", {7'd0, HS_IO_CLK_PAUSE}, 8'd0);
    chk("rst width", {5'd0, EYE_MONITOR_WIDTH_IN}, 8'd0);
    chk("rst slip",  {7'd0, RX_BIT_SLIP}, 8'd0);
    chk("rst ack",   {7'd0, ACK}, 8'd0);
    chk("rst busy",  {7'd0, BUSY}, 8'd0);
    chk("rst ready", {7'd0, LANE_READY}, 8'd0);
    chk("rst werr",  {7'd0, WIDTH_ERR}, 8'd0);
    chk("rst state", {5'd0, dbg_state}, 8'd0);
    chk("rst timer", dbg_timer, 8'd0);

    // Automatic init sequence after release.
    RESET = 1'b0;
    check_seq(3'b000, 3'b000, 1'b0, 1'b1, 1'b0);
    cur_w = 3'b000;

    // Table-driven requests.
    for (int i = 0; i < 6; i++) begin
      loop_en  = vecs[i].loop;
      forced_w = vecs[i].forced;
      do_req(vecs[i].req_width, vecs[i].req_slip);
      check_seq(cur_w, vecs[i].exp_width, vecs[i].req_slip, 1'b0, vecs[i].exp_err);
      cur_w = vecs[i].exp_width;
    end
    loop_en = 1'b1;

    // REQ held high for 40 cycles: exactly one accept and one ACK.
    do_req(3'b010, 1'b0);
    acks = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (ACK) acks++;
      if (k == 26) chk("held ack k=26", {7'd0, ACK}, 8'd1);
      if (k == 30) chk("held busy k=30", {7'd0, BUSY}, 8'd0);
      if (k == 35) chk("held pause k=35", {7'd0, HS_IO_CLK_PAUSE}, 8'd0);
    end
    chk("held ack count", 8'(acks), 8'd1);
    chk("held width", {5'd0, EYE_MONITOR_WIDTH_IN}, 8'd2);
    REQ = 1'b0;
    cur_w = 3'b010;
    // Second accept after REQ dropped.
    do_req(3'b001, 1'b0);
    check_seq(cur_w, 3'b001, 1'b0, 1'b0, 1'b0);
    cur_w = 3'b001;

    // Reset mid-sequence at T+6.
    do_req(3'b111, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 5) chk("pre-rst width k=5", {5'd0, EYE_MONITOR_WIDTH_IN}, 8'd7);
      if (k == 6) chk("pre-rst pause k=6", {7'd0, HS_IO_CLK_PAUSE}, 8'd1);
    end
    RESET = 1'b1;
    #1;
    chk("mid-rst pause", {7'd0, HS_IO_CLK_PAUSE}, 8'd0);
    chk("mid-rst width", {5'd0, EYE_MONITOR_WIDTH_IN}, 8'd0);
    chk("mid-rst ready", {7'd0, LANE_READY}, 8'd0);
    chk("mid-rst busy",  {7'd0, BUSY}, 8'd0);
    REQ = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("mid-rst ack", {7'd0, ACK}, 8'd0);
    end
    RESET = 1'b0;
    check_seq(3'b000, 3'b000, 1'b0, 1'b1, 1'b0);

    // Recovery: a normal request after the rerun init.
    do_req(3'b100, 1'b1);
    check_seq(3'b000, 3'b100, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
